// File: rtl/score_str_renderer.sv
`default_nettype none
// ============================================================================
// Module   : score_str_renderer
// Purpose  : Draws an N-glyph string from the "score" glyph ROM into a fixed
//            screen rectangle. Raster coordinates come in, a ROM row address
//            goes out, and the addressed glyph pixel comes back as a
//            registered on/off pixel. Two-cycle pipeline, one pixel per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1              pixel clock
//   reset_n_i      in   1              asynchronous active-low reset
//   en_i           in   1              active-video qualifier for x_i/y_i
//   x_i            in   coord_w_p      current pixel column
//   y_i            in   coord_w_p      current pixel row
//   frame_start_i  in   1              one-cycle pulse at start of each frame
//   rom_addr_o     out  clog2(depth_p) registered ROM row address
//   rom_data_i     in   width_p        ROM row data for rom_addr_o
//   pixel_o        out  1              glyph pixel lit
//   pixel_valid_o  out  1              pixel_o belongs to an active-video input
// ----------------------------------------------------------------------------
// Optional feature macro: SCORE_STR_BLINK_EN
//   When defined, the string blinks: it is shown for blink_frames_p frames
//   and hidden for blink_frames_p frames, counted on frame_start_i.
//   When undefined, the string is always visible and frame_start_i is unused.
// ============================================================================
module score_str_renderer #(
  parameter int width_p        = 32,
  parameter int glyph_h_p      = 64,
  parameter int depth_p        = 512,
  parameter int str_len_p      = 8,
  parameter int org_x_p        = 64,
  parameter int org_y_p        = 32,
  parameter int coord_w_p      = 11,
  parameter int blink_frames_p = 30
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic [coord_w_p-1:0]       x_i,
  input  logic [coord_w_p-1:0]       y_i,
  input  logic                       frame_start_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic                       pixel_o,
  output logic                       pixel_valid_o
);

  localparam int c_addr_w  = $clog2(depth_p);
  localparam int c_col_w   = $clog2(width_p);
  localparam int c_row_w   = $clog2(glyph_h_p);
  localparam int c_glyph_w = c_addr_w - c_row_w;

  // Box bounds evaluated in 32 bits so a box running past the coordinate
  // range is simply clipped at the coordinate maximum instead of wrapping.
  localparam logic [31:0] c_x_beg = 32'(org_x_p);
  localparam logic [31:0] c_x_end = 32'(org_x_p + str_len_p * width_p);
  localparam logic [31:0] c_y_beg = 32'(org_y_p);
  localparam logic [31:0] c_y_end = 32'(org_y_p + glyph_h_p);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter check
  // --------------------------------------------------------------------------
  if ((str_len_p * glyph_h_p > depth_p) ||
      ((width_p & (width_p - 1)) != 0) ||
      ((glyph_h_p & (glyph_h_p - 1)) != 0)) begin : g_param_check_fail
    $error("score_str_renderer: str_len_p*glyph_h_p > depth_p or non power-of-two width_p/glyph_h_p");
  end

  // --------------------------------------------------------------------------
  // Box geometry (combinational, ahead of stage 1)
  // --------------------------------------------------------------------------
  logic [coord_w_p:0]   w_dx;
  logic [coord_w_p:0]   w_dy;
  logic                 w_in_x;
  logic                 w_in_y;
  logic                 w_in_box;
  logic [c_glyph_w-1:0] w_glyph;
  logic [c_row_w-1:0]   w_row;
  logic [c_col_w-1:0]   w_col;

  assign w_dx = {1'b0, x_i} - (coord_w_p + 1)'(org_x_p);
  assign w_dy = {1'b0, y_i} - (coord_w_p + 1)'(org_y_p);

  assign w_in_x   = (32'(x_i) >= c_x_beg) && (32'(x_i) < c_x_end);
  assign w_in_y   = (32'(y_i) >= c_y_beg) && (32'(y_i) < c_y_end);
  assign w_in_box = en_i && w_in_x && w_in_y;

  // Power-of-two geometry: divide and modulo reduce to bit slices.
  assign w_glyph = w_dx[c_col_w +: c_glyph_w];
  assign w_row   = w_dy[c_row_w-1:0];
  assign w_col   = w_dx[c_col_w-1:0];

  // Upper difference bits only matter inside the compare above.
  logic unused_w;
  assign unused_w = ^{frame_start_i, w_dx, w_dy};

  // --------------------------------------------------------------------------
  // Stage 1: ROM address and pixel-column bookkeeping
  // --------------------------------------------------------------------------
  logic [c_addr_w-1:0] rom_addr_q, rom_addr_d;
  logic [c_col_w-1:0]  s1_col_q,   s1_col_d;
  logic                s1_in_q,    s1_in_d;
  logic                s1_v_q,     s1_v_d;

  always_comb begin
    rom_addr_d = '0;
    if (w_in_box) begin
      rom_addr_d = {w_glyph, w_row};
    end
    s1_col_d = w_col;
    s1_in_d  = w_in_box;
    s1_v_d   = en_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rom_addr_q <= '0;
      s1_col_q   <= '0;
      s1_in_q    <= 1'b0;
      s1_v_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      s1_col_q   <= s1_col_d;
      s1_in_q    <= s1_in_d;
      s1_v_q     <= s1_v_d;
    end
  end

  assign rom_addr_o = rom_addr_q;

  // --------------------------------------------------------------------------
  // Optional blink control
  // --------------------------------------------------------------------------
  logic w_vis;

`ifdef SCORE_STR_BLINK_EN
  localparam int c_cnt_w = (blink_frames_p > 1) ? $clog2(blink_frames_p) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(blink_frames_p - 1);

  logic [c_cnt_w-1:0] blink_cnt_q, blink_cnt_d;
  logic               vis_q,       vis_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    vis_d       = vis_q;
    if (frame_start_i) begin
      if (blink_cnt_q == c_cnt_last) begin
        blink_cnt_d = '0;
        vis_d       = ~vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // A frame_start_i pulse during reset is dropped by the async clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      blink_cnt_q <= '0;
      vis_q       <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      vis_q       <= vis_d;
    end
  end

  assign w_vis = vis_q;
`else
  assign w_vis = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Stage 2: pixel extraction
  // --------------------------------------------------------------------------
  // MSB of a ROM word is the leftmost pixel, so the bit index is
  // width_p-1-col, which for a power-of-two width is the bitwise inverse.
  logic [c_col_w-1:0] w_bit_idx;
  assign w_bit_idx = ~s1_col_q;

  logic pixel_q,       pixel_d;
  logic pixel_valid_q, pixel_valid_d;

  always_comb begin
    // The ROM word is only looked at for in-box pixels, so an unknown word
    // from an out-of-range ROM default cannot leak onto pixel_o.
    pixel_d = 1'b0;
    if (s1_in_q && w_vis) begin
      pixel_d = rom_data_i[w_bit_idx];
    end
    pixel_valid_d = s1_v_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pixel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_score_str_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_str_renderer
// Purpose  : Directed self-checking bench for score_str_renderer. A small
//            bench ROM answers rom_addr_o combinationally with known words;
//            every expected address and pixel is hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_str_renderer;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        en_i = 1'b0;
  logic [10:0] x_i = '0;
  logic [10:0] y_i = '0;
  logic        frame_start_i = 1'b0;
  logic [8:0]  rom_addr_o;
  logic [31:0] rom_data_i;
  logic        pixel_o;
  logic        pixel_valid_o;

  logic        rom_x = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  score_str_renderer #(
    .width_p        (32),
    .glyph_h_p      (64),
    .depth_p        (512),
    .str_len_p      (8),
    .org_x_p        (64),
    .org_y_p        (32),
    .coord_w_p      (11),
    .blink_frames_p (2)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .en_i          (en_i),
    .x_i           (x_i),
    .y_i           (y_i),
    .frame_start_i (frame_start_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Bench ROM: word 202 has only bit 26 set, word 511 only bit 0,
  // all others 0x7FC001FF (2143289855, MSB clear, next bit set).
  always_comb begin
    rom_data_i = 32'h7FC0_01FF;
    if (rom_x) begin
      rom_data_i = 'x;
    end else if (rom_addr_o == 9'd202) begin
      rom_data_i = 32'h0400_0000;
    end else if (rom_addr_o == 9'd511) begin
      rom_data_i = 32'h0000_0001;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel through the pipe: address after one edge, pixel after two.
  // Inputs are dropped after the first edge so the pixel must come from
  // the stage-1 sample of that edge.
  task automatic px(input string tag, input logic en, input int x, input int y,
                    input int exp_addr, input logic exp_pix);
    en_i = en;
    x_i  = 11'(x);
    y_i  = 11'(y);
    @(posedge clk_i); #1;
    chk({tag, ".addr"}, 32'(rom_addr_o), 32'(exp_addr));
    en_i = 1'b0;
    x_i  = '0;
    y_i  = '0;
    @(posedge clk_i); #1;
    chk({tag, ".pix"}, 32'(pixel_o), 32'(exp_pix));
    chk({tag, ".vld"}, 32'(pixel_valid_o), 32'(en));
  endtask

  task automatic frame_pulse();
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err = n_err + 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_blink;

    // Reset state
    #3 reset_n_i = 1'b0;
    #1;
    chk("rst.addr", 32'(rom_addr_o), 32'd0);
    chk("rst.pix",  32'(pixel_o), 32'd0);
    chk("rst.vld",  32'(pixel_valid_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Top-left glyph row 11: col 0 is the clear MSB, col 1 is set
    px("tl0", 1'b1, 64, 43, 11, 1'b0);
    px("tl1", 1'b1, 65, 43, 11, 1'b1);

    // Glyph 3, row 10, col 5 -> bit 26 of word 202; col 4 -> bit 27 clear
    px("g3c5", 1'b1, 165, 42, 202, 1'b1);
    px("g3c4", 1'b1, 164, 42, 202, 1'b0);

    // Edges outside the box with an unknown ROM word
    rom_x = 1'b1;
    px("xl", 1'b1, 63, 43, 0, 1'b0);
    px("xr", 1'b1, 320, 43, 0, 1'b0);
    px("yt", 1'b1, 100, 31, 0, 1'b0);
    px("yb", 1'b1, 100, 96, 0, 1'b0);
    rom_x = 1'b0;

    // Bottom-right corner: glyph 7, row 63, col 31 -> bit 0 of word 511
    px("br", 1'b1, 319, 95, 511, 1'b1);

    // Enable low on a lit pixel
    px("enlo", 1'b0, 65, 43, 0, 1'b0);

    // Enable pattern 1,0,1 streamed on a lit pixel
    x_i  = 11'd65;
    y_i  = 11'd43;
    en_i = 1'b1;
    @(posedge clk_i); #1;
    en_i = 1'b0;
    @(posedge clk_i); #1;
    chk("en0.pix", 32'(pixel_o), 32'd1);
    chk("en0.vld", 32'(pixel_valid_o), 32'd1);
    en_i = 1'b1;
    @(posedge clk_i); #1;
    chk("en1.pix", 32'(pixel_o), 32'd0);
    chk("en1.vld", 32'(pixel_valid_o), 32'd0);
    en_i = 1'b0;
    @(posedge clk_i); #1;
    chk("en2.pix", 32'(pixel_o), 32'd1);
    chk("en2.vld", 32'(pixel_valid_o), 32'd1);
    @(posedge clk_i); #1;

    // Blink: two frame pulses hide the string, two more show it again
`ifdef SCORE_STR_BLINK_EN
    exp_blink = 1'b0;
`else
    exp_blink = 1'b1;
`endif
    frame_pulse();
    frame_pulse();
    px("blk1", 1'b1, 65, 43, 11, exp_blink);
    frame_pulse();
    frame_pulse();
    px("blk2", 1'b1, 65, 43, 11, 1'b1);

    // Asynchronous reset mid-stream
    x_i  = 11'd65;
    y_i  = 11'd43;
    en_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("pre.pix", 32'(pixel_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst.addr", 32'(rom_addr_o), 32'd0);
    chk("arst.pix",  32'(pixel_o), 32'd0);
    chk("arst.vld",  32'(pixel_valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("hold.addr", 32'(rom_addr_o), 32'd0);
    chk("hold.pix",  32'(pixel_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rel.addr", 32'(rom_addr_o), 32'd11);
    @(posedge clk_i); #1;
    chk("rel.pix", 32'(pixel_o), 32'd1);
    en_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_str_renderer.md
Name: score_str_renderer

Overview:
- Pixel-stream consumer of the 32-bit-wide, 512-entry "score" glyph ROM.
- Takes raster coordinates from the VGA timing generator and drives the ROM row address.
- Extracts the addressed glyph pixel and emits a registered on/off pixel to the colour mixer.
- Places an N-glyph string in a fixed screen rectangle; 2-cycle pipeline, one pixel per clock.

Parameters:
- width_p, 32, glyph width in pixels = ROM word width (power of two)
- glyph_h_p, 64, glyph height in rows (power of two)
- depth_p, 512, ROM depth in words
- str_len_p, 8, glyphs drawn = depth_p/glyph_h_p
- org_x_p, 64, left pixel column of the string box
- org_y_p, 32, top pixel row of the string box
- coord_w_p, 11, coordinate width
- blink_frames_p, 30, frames per blink half-period (optional feature only)

Ports:
- clk_i  in  1  pixel clock
- reset_n_i  in  1  asynchronous active-low reset
- en_i  in  1  active-video qualifier for x_i/y_i
- x_i  in  coord_w_p  current pixel column
- y_i  in  coord_w_p  current pixel row
- frame_start_i  in  1  one-cycle pulse at the start of each frame
- rom_addr_o  out  $clog2(depth_p)  registered ROM address
- rom_data_i  in  width_p  ROM row data (combinational ROM, same cycle as rom_addr_o)
- pixel_o  out  1  glyph pixel lit
- pixel_valid_o  out  1  pixel_o corresponds to an active-video input

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (reset_n_i). Asserting it clears all flops immediately, including mid-frame.
- Reset values: rom_addr_o=0, pixel_o=0, pixel_valid_o=0, all stage registers=0.
- Box geometry: dx = x_i-org_x_p, dy = y_i-org_y_p, computed unsigned in coord_w_p+1 bits. in_box = en_i & x_i>=org_x_p & x_i<org_x_p+str_len_p*width_p & y_i>=org_y_p & y_i<org_y_p+glyph_h_p. The right and bottom edges are exclusive.
- Stage 1 (registered at clock edge k):
  - glyph = dx/width_p; row = dy mod glyph_h_p; col = dx mod width_p (shifts and masks only, no dividers).
  - rom_addr_o <= glyph*glyph_h_p + row when in_box, else 0.
  - Register s1_col<=col, s1_in<=in_box, s1_v<=en_i.
- Stage 2 (edge k+1):
  - pixel_o <= s1_in & rom_data_i[width_p-1-s1_col]. The MSB of each ROM word is the leftmost pixel.
  - pixel_valid_o <= s1_v.
- Latency: exactly 2 cycles from x_i/y_i/en_i to pixel_o/pixel_valid_o. Throughput is 1 pixel/cycle with no stalls.
- X protection: when s1_in=0, rom_data_i is ignored, so an X (from an out-of-range ROM default) never reaches pixel_o.
- Outside the box or with en_i low: pixel_o=0. pixel_valid_o follows en_i delayed by 2.
- frame_start_i has no effect on the pipeline. It is used only by the optional feature.
- Wrap-around: if org_x_p+str_len_p*width_p exceeds 2^coord_w_p, the box is clipped at the coordinate maximum. The column does not wrap to 0.
- Parameter check: an elaboration-time assertion fails if str_len_p*glyph_h_p>depth_p or if width_p/glyph_h_p is not a power of two.

Optional Feature:
- Macro: SCORE_STR_BLINK_EN.
- Defined:
  - Adds a frame counter (width $clog2(blink_frames_p)) and a vis flag. Reset values are counter=0, vis=1.
  - On frame_start_i with counter==blink_frames_p-1: counter<=0 and vis toggles. Otherwise, on frame_start_i, counter increments.
  - Stage 2 becomes pixel_o <= vis & s1_in & bit.
  - A frame_start_i coincident with reset is ignored.
- Undefined: no counter or vis logic; string always visible; frame_start_i is unused.

Test Plan:
- Reset: reset_n_i=0 asynchronously mid-stream -> rom_addr_o, pixel_o, pixel_valid_o = 0 before the next edge; hold 0 until release.
- Top-left pixel: en_i=1, x=64, y=43 -> rom_addr_o=11 after 1 cycle. With rom_data_i=2143289855 (MSB 0), pixel_o=0 after 2 cycles; x=65 -> pixel_o=1.
- Glyph index: x=64+32*3+5, y=32+10 -> rom_addr_o=3*64+10=202; pixel_o = bit 26 of rom_data_i.
- Edges: x=63, x=320, y=31, y=96 -> pixel_o=0 and rom_addr_o=0. A ROM driven to all-X during these must not produce X on pixel_o. x=319, y=95 -> in box, addr=511.
- Enable: en_i pattern 1,0,1 on an in-box lit pixel -> pixel_valid_o 1,0,1 delayed 2 cycles; pixel_o 1,0,1.
- Blink (macro defined, blink_frames_p=2): 2 frame_start_i pulses -> pixel_o forced 0 on lit pixels; 2 more pulses -> visible again. With the macro undefined, the same stimulus leaves the string always visible.
